// File: rtl/display_scan_if.sv
// Bundle of the scan controller's value/handshake, decoder and display pins.
// The controller side uses the slave modport; the host/board side uses master.
interface display_scan_if #(
    parameter int DIGITS = 4
) ();
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  blank_lz;
    logic                  ack;
    logic [3:0]            bin;
    logic [6:0]            seg_in;
    logic [6:0]            seg_out;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;

    modport master (
        output en, load, value, blank_lz, seg_in,
        input  ack, bin, seg_out, an, frame_done
    );

    modport slave (
        input  en, load, value, blank_lz, seg_in,
        output ack, bin, seg_out, an, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller sharing one external decoder.
// Values are double-buffered and only swapped in at frame boundaries.
module display_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic          clk,
    input  logic          rst,
    display_scan_if.slave bus
);
    localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DW-1:0]  DIG_LAST = DW'(DIGITS - 1);
    localparam logic [PCW-1:0] PC_LAST  = PCW'(PRESCALE - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [4*DIGITS-1:0] pending_r;
    logic                pend_v_r;
    logic [4*DIGITS-1:0] active_r;
    logic [DW-1:0]       dig_r;
    logic [PCW-1:0]      pc_r;
    logic                ack_r;
    logic [6:0]          seg_out_r;
    logic [DIGITS-1:0]   an_r;
    logic                frame_done_r;

    logic                scan_s;
    logic                adv_s;
    logic                wrap_s;
    logic                start_s;
    logic                take_s;
    logic [DIGITS-1:0]   an_s;
    logic [6:0]          seg_s;

    // Digit i is dark when blanking is on, i is not digit 0 and nibbles i..top are zero.
    function automatic logic blk(input logic [4*DIGITS-1:0] v,
                                 input logic [DW-1:0]       i,
                                 input logic                lz);
        logic zero;
        zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if ((k >= int'(i)) && (v[4*k +: 4] != 4'h0)) begin
                zero = 1'b0;
            end
        end
        return lz && (i != {DW{1'b0}}) && zero;
    endfunction

    assign scan_s  = (state_r == ST_SCAN) && bus.en;
    assign adv_s   = scan_s && (pc_r == PC_LAST);
    assign wrap_s  = adv_s && (dig_r == DIG_LAST);
    assign start_s = (state_r == ST_BLANK) && pend_v_r;
    // A swap always consumes the pending value that existed before this edge.
    assign take_s  = (start_s || wrap_s) && pend_v_r;
    assign an_s    = {{(DIGITS-1){1'b0}}, 1'b1} << dig_r;

    // Next-state logic: leave BLANK once a value is waiting; SCAN is left only by reset.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_BLANK: begin
                if (pend_v_r) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_BLANK;
                end
            end
            ST_SCAN:  state_s = ST_SCAN;
            default:  state_s = ST_BLANK;
        endcase
    end

    // Segment selection for the digit currently addressed.
    always_comb begin
        seg_s = 7'h00;
        if (blk(active_r, dig_r, bus.blank_lz)) begin
            seg_s = 7'h00;
        end else begin
            seg_s = bus.seg_in;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_BLANK;
        end else begin
            state_r <= state_s;
        end
    end

    // Value buffers, scan counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r    <= {(4*DIGITS){1'b0}};
            pend_v_r     <= 1'b0;
            active_r     <= {(4*DIGITS){1'b0}};
            dig_r        <= {DW{1'b0}};
            pc_r         <= {PCW{1'b0}};
            ack_r        <= 1'b0;
            seg_out_r    <= 7'h00;
            an_r         <= {DIGITS{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            ack_r        <= bus.load;
            frame_done_r <= wrap_s;
            if (bus.load) begin
                pending_r <= bus.value;
                pend_v_r  <= 1'b1;
            end else if (take_s) begin
                pend_v_r  <= 1'b0;
            end
            if (take_s) begin
                active_r <= pending_r;
            end
            if (start_s) begin
                dig_r <= {DW{1'b0}};
                pc_r  <= {PCW{1'b0}};
            end else if (adv_s) begin
                pc_r  <= {PCW{1'b0}};
                dig_r <= wrap_s ? {DW{1'b0}} : dig_r + {{(DW-1){1'b0}}, 1'b1};
            end else if (scan_s) begin
                pc_r  <= pc_r + {{(PCW-1){1'b0}}, 1'b1};
            end
            if (scan_s) begin
                an_r      <= an_s;
                seg_out_r <= seg_s;
            end else begin
                an_r      <= {DIGITS{1'b0}};
                seg_out_r <= 7'h00;
            end
        end
    end

    assign bus.bin        = active_r[4*int'(dig_r) +: 4];
    assign bus.ack        = ack_r;
    assign bus.seg_out    = seg_out_r;
    assign bus.an         = an_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised + directed bench for display_scan_ctrl (DIGITS=4, PRESCALE=4) with a
// frame-position reference model and an attached seven-segment decoder model.
module tb_display_scan_ctrl;
    localparam int D = 4;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_scan_if #(.DIGITS(D)) bus ();

    display_scan_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    assign bus.seg_in = seg7(bus.bin);

    int n_cmp = 0;
    int n_err = 0;

    // reference model: position within the frame in enabled scan cycles
    logic [15:0] m_pending = 16'h0;
    logic [15:0] m_active  = 16'h0;
    bit          m_pv      = 1'b0;
    bit          m_scan    = 1'b0;
    int          m_pos     = 0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic [3:0]  e_bin;
    bit          e_ack, e_fd;

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        logic [15:0] s;
        s = v >> (4 * d);
        return s[3:0];
    endfunction

    function automatic bit dark(input logic [15:0] v, input int d, input bit lz);
        return lz && (d != 0) && ((v >> (4 * d)) == 16'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit take;
        int d;
        take  = 1'b0;
        e_an  = 4'b0000;
        e_seg = 7'h00;
        e_fd  = 1'b0;
        e_ack = 1'b0;
        if (rst) begin
            m_scan = 1'b0; m_pv = 1'b0; m_active = 16'h0; m_pos = 0;
        end else begin
            e_ack = bus.load;
            if (!m_scan) begin
                if (m_pv) begin
                    take = 1'b1; m_scan = 1'b1; m_pos = 0;
                end
            end else if (bus.en) begin
                d     = m_pos / P;
                e_an  = 4'(1 << d);
                e_seg = dark(m_active, d, bus.blank_lz) ? 7'h00 : seg7(nib(m_active, d));
                if (m_pos == D * P - 1) begin
                    e_fd  = 1'b1;
                    m_pos = 0;
                    take  = m_pv;
                end else begin
                    m_pos++;
                end
            end
            if (take) begin
                m_active = m_pending;
                m_pv     = 1'b0;
            end
            if (bus.load) begin
                m_pending = bus.value;
                m_pv      = 1'b1;
            end
        end
        e_bin = nib(m_active, m_pos / P);
    endtask

    // One clock: advance the model, let the edge happen, compare every output.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("ack",        32'(bus.ack),        32'(e_ack));
        chk("an",         32'(bus.an),         32'(e_an));
        chk("seg_out",    32'(bus.seg_out),    32'(e_seg));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        chk("bin",        32'(bus.bin),        32'(e_bin));
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load  = 1'b1;
        bus.value = v;
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = bus.frame_done;
        end
        if (!seen) chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0; bus.value = 16'h0; bus.blank_lz = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("idle_an", 32'(bus.an), 32'h0);

        // first display of 0x1234
        bus.en = 1'b1;
        do_load(16'h1234);
        tick();
        tick();
        chk("first_an",  32'(bus.an),      32'h1);
        chk("first_seg", 32'(bus.seg_out), 32'h66);
        for (int i = 0; i < 4; i++) tick();
        chk("dig1_an",  32'(bus.an),      32'h2);
        chk("dig1_seg", 32'(bus.seg_out), 32'h4F);

        // mid-frame load only appears after the wrap
        do_load(16'hABCD);
        wait_fd("wait_wrap_abcd");
        tick();
        chk("abcd_an",  32'(bus.an),      32'h1);
        chk("abcd_seg", 32'(bus.seg_out), 32'h5E);
        k = 0;
        do begin tick(); k++; end while (!bus.frame_done && k < 40);
        chk("frame_period", 32'(k), 32'd15);

        // leading-zero blanking
        bus.blank_lz = 1'b1;
        do_load(16'h0005);
        wait_fd("wait_wrap_0005");
        tick();
        chk("lz5_seg0", 32'(bus.seg_out), 32'h6D);
        for (int i = 0; i < 4; i++) tick();
        chk("lz5_an1",   32'(bus.an),      32'h2);
        chk("lz5_seg1",  32'(bus.seg_out), 32'h0);
        do_load(16'h0000);
        wait_fd("wait_wrap_0000");
        tick();
        chk("lz0_seg0", 32'(bus.seg_out), 32'h3F);

        // enable drop at dig 2, pc 1
        bus.blank_lz = 1'b0;
        k = 0;
        while (m_pos != 9 && k < 64) begin tick(); k++; end
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("hold_an",  32'(bus.an),      32'h0);
        chk("hold_seg", 32'(bus.seg_out), 32'h0);
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("resume_an2", 32'(bus.an), 32'h4);
        tick();
        chk("resume_an3", 32'(bus.an), 32'h8);

        // reset mid-frame discards the pending value
        do_load(16'h7777);
        rst = 1'b1;
        tick();
        chk("rst_an",  32'(bus.an),      32'h0);
        chk("rst_seg", 32'(bus.seg_out), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("post_rst_an", 32'(bus.an), 32'h0);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 399) == 0);
            bus.en       = ($urandom_range(0, 7) != 0);
            bus.load     = ($urandom_range(0, 23) == 0);
            bus.value    = ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
            if ($urandom_range(0, 99) == 0) bus.blank_lz = ~bus.blank_lz;
            tick();
        end
        bus.load = 1'b0;
        rst      = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
